// File: rtl/image_store.sv
// image_store: dual-plane DIM x DIM RGB frame store for the image engine.
// Loads a raster-order frame, serves registered engine reads from the read
// plane, captures engine writes into the other plane, swaps planes on engine
// phase flags and streams the finished plane out with valid/ready flow control.
module image_store #(
  parameter int DIM = 64,
  parameter int AW  = 6,
  parameter int PW  = 24
) (
  input  logic          clk,
  input  logic          rst,
  // load stream
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [PW-1:0] s_pix,
  // engine port
  input  logic [AW-1:0] row,
  input  logic [AW-1:0] col,
  output logic [PW-1:0] in_pix,
  input  logic          out_we,
  input  logic [PW-1:0] out_pix,
  input  logic          mirror_done,
  input  logic          gray_done,
  input  logic          filter_done,
  output logic          start,
  // result stream
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_pix,
  output logic          m_last,
  output logic          frame_done
);

  localparam int NPIX = DIM * DIM;
  localparam int IW   = 2 * AW;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;

  // pixel planes P0 and P1
  logic [PW-1:0] r_plane0 [NPIX];
  logic [PW-1:0] r_plane1 [NPIX];

  // control state
  logic [1:0]    r_state;
  logic          r_bank;
  logic [IW-1:0] r_load_cnt;
  logic          r_start;
  logic          r_frame_done;
  logic          r_mirror_q;
  logic          r_gray_q;
  logic          r_filter_q;
  logic [PW-1:0] r_in_pix;

  // dump pipeline: address issue -> read register -> output / skid registers
  logic [IW-1:0] r_dump_addr;
  logic          r_issue_done;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [PW-1:0] r_rd_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic [PW-1:0] r_out_pix;
  logic          r_skid_valid;
  logic          r_skid_last;
  logic [PW-1:0] r_skid_pix;

  // combinational helpers
  logic [IW-1:0] w_eng_addr;
  logic          w_load;
  logic          w_run;
  logic          w_dump;
  logic          w_load_hs;
  logic          w_load_last;
  logic          w_mirror_rise;
  logic          w_gray_rise;
  logic          w_filter_rise;
  logic          w_toggle;
  logic          w_to_dump;
  logic          w_pop;
  logic          w_final_hs;
  logic [1:0]    w_occ;
  logic          w_issue;
  logic          w_wr_p0;
  logic          w_wr_p1;
  logic [IW-1:0] w_wr0_addr;
  logic [PW-1:0] w_wr0_data;

  // DIM is a power of two, so row*DIM+col is a plain concatenation
  assign w_eng_addr  = {row, col};

  assign w_load      = (r_state == ST_LOAD);
  assign w_run       = (r_state == ST_RUN);
  assign w_dump      = (r_state == ST_DUMP);

  assign w_load_hs   = w_load & s_valid;
  assign w_load_last = w_load_hs & (r_load_cnt == '1);

  // rising edges only matter in RUN; in LOAD the q registers simply track
  assign w_mirror_rise = mirror_done & ~r_mirror_q;
  assign w_gray_rise   = gray_done   & ~r_gray_q;
  assign w_filter_rise = filter_done & ~r_filter_q;

  // two simultaneous rises cancel out, hence XOR
  assign w_toggle  = w_run & (w_mirror_rise ^ w_gray_rise);
  assign w_to_dump = w_run & w_filter_rise;

  assign w_pop      = r_out_valid & m_ready;
  assign w_final_hs = w_pop & r_out_last;

  // entries held or in flight after this edge's pop; two slots (out + skid)
  // exist, so a new read is issued only when one is guaranteed free
  assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_rd_valid}
                 - {1'b0, w_pop};
  assign w_issue = w_dump & ~r_issue_done & (w_occ < 2'd2);

  // LOAD always fills P0; RUN writes land in the current write plane
  assign w_wr_p0    = w_load_hs | (w_run & out_we & r_bank);
  assign w_wr_p1    = w_run & out_we & ~r_bank;
  assign w_wr0_addr = w_load ? r_load_cnt : w_eng_addr;
  assign w_wr0_data = w_load ? s_pix : out_pix;

  // plane P0 write port
  // NOTE: frame memories carry no reset; their contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr_p0) begin
      r_plane0[w_wr0_addr] <= w_wr0_data;
    end
  end

  // plane P1 write port (engine writes only)
  always_ff @(posedge clk) begin
    if (w_wr_p1) begin
      r_plane1[w_eng_addr] <= out_pix;
    end
  end

  // dump read of the write plane; its valid flag lives in the reset domain
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_rd_data <= r_bank ? r_plane0[r_dump_addr] : r_plane1[r_dump_addr];
    end
  end

  // engine read of the read plane, every edge in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_pix <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_in_pix <= r_bank ? r_plane1[w_eng_addr] : r_plane0[w_eng_addr];
    end
  end

  // state machine, plane select, load counter, pulses and flag history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_bank       <= 1'b0;
      r_load_cnt   <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_mirror_q   <= 1'b0;
      r_gray_q     <= 1'b0;
      r_filter_q   <= 1'b0;
    end else begin
      r_mirror_q   <= mirror_done;
      r_gray_q     <= gray_done;
      r_filter_q   <= filter_done;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_load_hs) begin
            r_load_cnt <= r_load_cnt + 1'b1;
            if (w_load_last) begin
              r_state <= ST_RUN;
              r_start <= 1'b1;
              r_bank  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (w_to_dump) begin
            r_state <= ST_DUMP;
          end else if (w_toggle) begin
            r_bank <= ~r_bank;
          end
        end
        ST_DUMP: begin
          if (w_final_hs) begin
            r_state      <= ST_LOAD;
            r_frame_done <= 1'b1;
            r_bank       <= 1'b0;
            r_load_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  // dump address issue, read stage and two-entry output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dump_addr  <= '0;
      r_issue_done <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_pix    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_pix   <= '0;
    end else if (!w_dump) begin
      r_dump_addr  <= '0;
      r_issue_done <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      // read stage
      r_rd_valid <= w_issue;
      if (w_issue) begin
        r_rd_last   <= (r_dump_addr == '1);
        r_dump_addr <= r_dump_addr + 1'b1;
        if (r_dump_addr == '1) begin
          r_issue_done <= 1'b1;
        end
      end
      // output register advances when empty or consumed; skid is always older
      // than the read stage, so it drains first
      if (!r_out_valid || w_pop) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_pix    <= r_skid_pix;
          r_out_last   <= r_skid_last;
          r_skid_valid <= r_rd_valid;
          r_skid_pix   <= r_rd_data;
          r_skid_last  <= r_rd_last;
        end else begin
          r_out_valid <= r_rd_valid;
          r_out_pix   <= r_rd_data;
          r_out_last  <= r_rd_last;
        end
      end else if (r_rd_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_pix   <= r_rd_data;
        r_skid_last  <= r_rd_last;
      end
    end
  end

  assign s_ready    = w_load;
  assign in_pix     = r_in_pix;
  assign start      = r_start;
  assign m_valid    = r_out_valid;
  assign m_pix      = r_out_pix;
  assign m_last     = r_out_last;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_image_store.sv
// tb_image_store: directed self-checking bench for image_store.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_image_store;

  localparam int DIM = 64;
  localparam int AW  = 6;
  localparam int PW  = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_pix = '0;
  logic [AW-1:0] row = '0;
  logic [AW-1:0] col = '0;
  logic [PW-1:0] in_pix;
  logic          out_we = 1'b0;
  logic [PW-1:0] out_pix = '0;
  logic          mirror_done = 1'b0;
  logic          gray_done = 1'b0;
  logic          filter_done = 1'b0;
  logic          start;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [PW-1:0] m_pix;
  logic          m_last;
  logic          frame_done;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  image_store #(.DIM(DIM), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix),
    .row(row), .col(col), .in_pix(in_pix),
    .out_we(out_we), .out_pix(out_pix),
    .mirror_done(mirror_done), .gray_done(gray_done), .filter_done(filter_done),
    .start(start),
    .m_valid(m_valid), .m_ready(m_ready), .m_pix(m_pix), .m_last(m_last),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected content of the dumped plane: loaded frame plus three overwrites
  function automatic logic [23:0] exp_dump(input int k);
    case (k)
      0:       return 24'h111111;
      660:     return 24'h333333;
      4095:    return 24'h222222;
      default: return {k[11:0], k[11:0]};
    endcase
  endfunction

  // streams pixel k = {k,k} for the whole frame with s_valid held high
  task automatic load_frame(input string tag);
    int bad = 0;
    s_valid = 1'b1;
    for (int k = 0; k < DIM * DIM; k++) begin
      s_pix = {k[11:0], k[11:0]};
      @(negedge clk);
      if (k < DIM * DIM - 1 && (start !== 1'b0 || s_ready !== 1'b1)) bad++;
    end
    s_valid = 1'b0;
    check({tag, "_early_start_or_stall"}, bad, 0);
    check({tag, "_start_pulse"}, start, 1);
    check({tag, "_sready_drop"}, s_ready, 0);
    @(negedge clk);
    check({tag, "_start_width"}, start, 0);
  endtask

  initial begin
    bit ready_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int idx, perr, lerr, serr, fd, lasts, hs, cyc;
    bit prev_stall;

    // ---- reset values
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_in_pix", in_pix, 0);
    check("rst_start", start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_pix", m_pix, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    // ---- load frame 1 and read back corners
    load_frame("load1");
    row = 6'd0; col = 6'd0;
    @(negedge clk);
    check("read_0_0", in_pix, 24'h000000);
    row = 6'd63; col = 6'd63;
    @(negedge clk);
    check("read_63_63", in_pix, 24'hFFFFFF);
    row = 6'd1; col = 6'd2;
    @(negedge clk);
    check("read_1_2", in_pix, 24'h042042);

    // ---- simultaneous mirror+gray rise leaves the planes unswapped
    mirror_done = 1'b1; gray_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("dual_rise_no_swap", in_pix, 24'h042042);
    mirror_done = 1'b0; gray_done = 1'b0;
    @(negedge clk);

    // ---- write to the write plane, then swap with mirror_done
    row = 6'd5; col = 6'd7; out_pix = 24'hABCDEF; out_we = 1'b1;
    @(negedge clk);
    out_we = 1'b0; mirror_done = 1'b1;
    @(negedge clk);
    check("pre_toggle_read", in_pix, 24'h147147);
    @(negedge clk);
    check("post_toggle_read", in_pix, 24'hABCDEF);

    // ---- overwrite three pixels of the new write plane (P0)
    out_we = 1'b1;
    row = 6'd0;  col = 6'd0;  out_pix = 24'h111111; @(negedge clk);
    row = 6'd63; col = 6'd63; out_pix = 24'h222222; @(negedge clk);
    row = 6'd10; col = 6'd20; out_pix = 24'h333333; @(negedge clk);
    out_we = 1'b0;

    // ---- dump with a 1-0-1-1-0 ready pattern
    filter_done = 1'b1; m_ready = 1'b0;
    @(negedge clk);                       // DUMP entered
    @(negedge clk);
    check("dump_lat_not_yet", m_valid, 0);
    @(negedge clk);
    check("dump_first_valid", m_valid, 1);
    check("dump_first_pix", m_pix, exp_dump(0));

    idx = 0; perr = 0; lerr = 0; serr = 0; fd = 0; lasts = 0; prev_stall = 1'b0;
    for (int c = 0; c < 20000 && idx < DIM * DIM; c++) begin
      m_ready = ready_pat[c % 5];
      if (m_valid) begin
        if (m_pix !== exp_dump(idx)) perr++;
        if (m_last !== (idx == DIM * DIM - 1)) lerr++;
        if (m_ready && m_last) lasts++;
        if (m_ready) idx++;
        prev_stall = !m_ready;
      end else begin
        if (prev_stall) serr++;
        prev_stall = 1'b0;
      end
      if (frame_done) fd++;
      @(negedge clk);
    end
    check("dump_count", idx, DIM * DIM);
    check("dump_pix_errors", perr, 0);
    check("dump_last_errors", lerr, 0);
    check("dump_stall_drop_errors", serr, 0);
    check("dump_last_count", lasts, 1);
    check("dump_frame_done", frame_done, 1);
    check("dump_valid_drop", m_valid, 0);
    check("dump_back_to_load", s_ready, 1);
    m_ready = 1'b0;
    fd += int'(frame_done);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (frame_done) fd++;
    end
    check("frame_done_once", fd, 1);

    // ---- reload with a stale mirror_done still high
    filter_done = 1'b0;
    load_frame("load2");
    row = 6'd1; col = 6'd2; out_pix = 24'h5A5A5A; out_we = 1'b1;
    @(negedge clk);
    out_we = 1'b0;
    @(negedge clk);
    check("stale_flag_no_toggle", in_pix, 24'h042042);
    mirror_done = 1'b0;
    @(negedge clk);
    check("flag_fall_no_toggle", in_pix, 24'h042042);
    mirror_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rearmed_flag_toggles", in_pix, 24'h5A5A5A);

    // ---- full-rate dump, then reset after 100 pixels
    filter_done = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 50 && !m_valid; c++) @(negedge clk);
    check("dump2_valid_seen", m_valid, 1);
    hs = 0; cyc = 0;
    while (hs < 100 && cyc < 1000) begin
      if (m_valid && m_ready) hs++;
      cyc++;
      @(negedge clk);
    end
    check("dump_full_rate", cyc, 100);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_pix", m_pix, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_in_pix", in_pix, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_start", start, 0);
    check("midrst_frame_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0; filter_done = 1'b0; mirror_done = 1'b0; m_ready = 1'b0;

    // ---- LOAD restarts at k=0: first pixel lands at (0,0) of P0
    s_valid = 1'b1; s_pix = 24'h777777;
    @(negedge clk);
    s_valid = 1'b0; row = 6'd0; col = 6'd0;
    @(negedge clk);
    check("reload_k0", in_pix, 24'h777777);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/image_store.md
# image_store

Dual-plane 64x64 RGB frame store that serves as the memory counterpart of the image processing engine. It loads an input frame from a pixel stream and answers the engine's `row`/`col` read requests with registered `in_pix`. It captures the engine's `out_we`/`out_pix` writes and swaps planes between processing passes. When `filter_done` rises, it streams the finished frame out.

## Interface
- `DIM`, 64, image side in pixels; must be a power of two.
- `AW`, 6, coordinate width, log2(DIM).
- `PW`, 24, pixel width (R 23:16, G 15:8, B 7:0).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  load pixel valid.
- `s_ready`  out  1  load pixel accepted when both are high.
- `s_pix`  in  PW  load pixel, raster order.
- `row`, `col`  in  AW each  engine read/write address.
- `in_pix`  out  PW  read data for the address sampled on the previous edge.
- `out_we`  in  1  engine write enable.
- `out_pix`  in  PW  engine write data.
- `mirror_done`, `gray_done`, `filter_done`  in  1 each  engine phase flags (level, stay high).
- `start`  out  1  one-cycle pulse: frame loaded, engine may run.
- `m_valid`  out  1  result pixel valid.
- `m_ready`  in  1  result sink ready.
- `m_pix`  out  PW  result pixel, raster order.
- `m_last`  out  1  high with pixel (DIM-1, DIM-1).
- `frame_done`  out  1  one-cycle pulse after the last result handshake.

## Operation
- Storage: planes P0 and P1, each DIM*DIM x PW.
  - Register `bank` selects the planes: read plane = P[bank], write plane = P[~bank].
  - Address = row*DIM + col.
- States:
  - LOAD (reset state): `s_ready`=1. Each handshake writes pixel k to P0 at (k/DIM, k%DIM) and increments k. Handshake number DIM*DIM (k wraps to 0) -> RUN, `start`=1 for that next cycle, `bank`=0.
  - RUN:
    - `out_we`=1 at an edge writes `out_pix` to the write plane at (`row`,`col`).
    - A rising edge of `mirror_done` or `gray_done` toggles `bank`. Simultaneous rising edges of both cause two toggles, i.e. `bank` is unchanged.
    - A rising edge of `filter_done` -> DUMP. It takes priority over a toggle in the same cycle.
    - A write in the same cycle as a toggle completes to the pre-toggle write plane.
  - DUMP: streams the write plane P[~bank] in raster order (the last pass wrote there).
    - The handshake on `m_last` -> LOAD, `frame_done`=1 for one cycle, `bank`<=0, k<=0.
- Engine reads: `in_pix` <= read plane[`row`,`col`] on every edge, in every state. The read and write planes differ, so there is no hazard.
- Writes: `out_we` is ignored outside RUN.
- Edge detect: the `*_done` previous-value registers reset to 0. In LOAD they track the inputs, so flags already high from a stale frame do not trigger in RUN.
- Reset mid-operation: state -> LOAD, k=0, `bank`=0, stream counters cleared. Memory contents are unchanged and need not be cleared.

## Timing
- Reset values: `s_ready`=1, `in_pix`=0, `start`=0, `m_valid`=0, `m_pix`=0, `m_last`=0, `frame_done`=0.
- Read latency: one cycle. If `row`/`col` are sampled at edge n, `in_pix` is valid after edge n, during cycle n+1.
- Load throughput: one pixel per cycle. `s_ready` drops in the cycle after the final handshake.
- DUMP output timing:
  - First pixel: `m_valid` rises two cycles after entering DUMP (one cycle address issue, one cycle read).
  - `m_pix` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.
  - With `m_ready` held high, the stream sustains one pixel per cycle (prefetch/skid register required).
  - `m_valid` drops the cycle after the last handshake.
- `start` and `frame_done` are exactly one cycle wide.

## Test plan
- Load pixels k = 0..4095 with value {k[11:0], k[11:0]}, `s_valid` always high. Then:
  - `start` pulses once, 1 cycle after handshake 4096.
  - Reading (0,0) gives 0x000000 next cycle; reading (63,63) gives 0xFFFFFF.
- RUN, write 0xABCDEF to (5,7) via `out_we`, then raise `mirror_done`:
  - A read of (5,7) one cycle after the toggle returns 0xABCDEF.
- RUN, raise `mirror_done` and `gray_done` on the same edge:
  - `bank` is unchanged; a read of (0,0) still returns the loaded value.
- Write a known pattern to the write plane, raise `filter_done`, drive `m_ready` with a 1-0-1-1-0 repeating pattern:
  - 4096 pixels arrive in raster order, each stable across stalls.
  - `m_last` is high only on the 4096th pixel; `frame_done` pulses once; the block returns to LOAD with `s_ready`=1.
- Assert `rst` during DUMP after 100 pixels:
  - All outputs return to reset values immediately; LOAD restarts at k=0.
- Reload a frame while `mirror_done` is still high from the previous frame:
  - No `bank` toggle occurs until the flag falls and rises again.
